// File: rtl/y_drain.sv
// Output drain for the systolic MAC array: captures a row of NUM accumulators on
// en_y and streams them over valid/ready. Optional clamping via `Y_SATURATE_EN.
module y_drain #(
    parameter int NUM   = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_y,
    input  logic [NUM*ACC_W-1:0]      y_in,
    input  logic                      y_ready,
    input  logic                      overrun_clr,
    output logic [OUT_W-1:0]          y_out,
    output logic                      y_valid,
    output logic [$clog2(NUM)-1:0]    y_idx,
    output logic                      y_last,
    output logic                      busy,
    output logic                      overrun
);

    localparam int IDX_W = $clog2(NUM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      sh_full_q, sh_full_d;
    logic                      overrun_q, overrun_d;
    logic signed [ACC_W-1:0]   main_q [NUM];
    logic signed [ACC_W-1:0]   main_d [NUM];
    logic signed [ACC_W-1:0]   sh_q   [NUM];
    logic signed [ACC_W-1:0]   sh_d   [NUM];
    logic signed [ACC_W-1:0]   row_in [NUM];
    logic signed [ACC_W-1:0]   rd_acc;
    logic [OUT_W-1:0]          conv_out;
    logic                      xfer, last_xfer, ovr_set;

`ifdef Y_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] clamped;
        if (acc > SAT_MAX)      clamped = SAT_MAX;
        else if (acc < SAT_MIN) clamped = SAT_MIN;
        else                    clamped = acc;
        return clamped[OUT_W-1:0];
    endfunction

    assign conv_out = saturate(rd_acc);
`else
    assign conv_out = rd_acc[OUT_W-1:0];
    generate
        if (OUT_W < ACC_W) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^rd_acc[ACC_W-1:OUT_W];
        end
    endgenerate
`endif

    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            row_in[k] = y_in[k*ACC_W +: ACC_W];
        end
    end

    assign rd_acc    = main_q[idx_q];
    assign y_valid   = (state_q == DRAIN);
    assign xfer      = y_valid && y_ready;
    assign last_xfer = xfer && (idx_q == IDX_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sh_full_d = sh_full_q;
        main_d    = main_q;
        sh_d      = sh_q;
        ovr_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_y) begin
                    main_d  = row_in;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    idx_d = '0;
                    // Refill main on the final beat so the next row starts without a bubble.
                    if (sh_full_q) begin
                        main_d = sh_q;
                        if (en_y) sh_d      = row_in;
                        else      sh_full_d = 1'b0;
                    end else if (en_y) begin
                        main_d = row_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) idx_d = idx_q + 1'b1;
                    if (en_y) begin
                        if (!sh_full_q) begin
                            sh_d      = row_in;
                            sh_full_d = 1'b1;
                        end else begin
                            ovr_set = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh overrun outranks a simultaneous clear.
        overrun_d = ovr_set | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sh_full_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sh_full_q <= sh_full_d;
            overrun_q <= overrun_d;
        end
    end

    // Row storage is qualified by state/sh_full, so it carries no reset.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        sh_q   <= sh_d;
    end

    assign y_out   = y_valid ? conv_out : '0;
    assign y_idx   = idx_q;
    assign y_last  = y_valid && (idx_q == IDX_LAST);
    assign busy    = y_valid || sh_full_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_y_drain.sv
// Directed self-checking bench for y_drain (NUM=4, ACC_W=32, OUT_W=16).
module tb_y_drain;
    localparam int NUM = 4, ACC_W = 32, OUT_W = 16;

    logic clk, reset, en_y, y_ready, overrun_clr;
    logic [NUM*ACC_W-1:0] y_in;
    logic [OUT_W-1:0] y_out;
    logic y_valid, y_last, busy, overrun;
    logic [1:0] y_idx;
    int checks = 0, errors = 0;

    y_drain #(.NUM(NUM), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .en_y(en_y), .y_in(y_in), .y_ready(y_ready),
        .overrun_clr(overrun_clr), .y_out(y_out), .y_valid(y_valid), .y_idx(y_idx),
        .y_last(y_last), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM*ACC_W-1:0] pack(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic test_reset();
        reset = 1'b0; en_y = 0; y_ready = 0; overrun_clr = 0; y_in = '0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({y_valid, y_last, busy, overrun, y_idx, y_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b o=%b idx=%0d out=%h, expected all 0",
                     y_valid, y_last, busy, overrun, y_idx, y_out);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_row();
        y_in = pack(1, 2, 3, 4); en_y = 1; y_ready = 1;
        @(negedge clk);
        en_y = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({y_valid, y_idx, y_last, y_out} !== {1'b1, 2'(k), (k == 3), 16'(k + 1)}) begin
                errors++;
                $display("FAIL single_row[%0d]: got v=%b idx=%0d last=%b out=%h, expected v=1 idx=%0d last=%b out=%h",
                         k, y_valid, y_idx, y_last, y_out, k, (k == 3), k + 1);
            end
            @(negedge clk);
        end
        checks++;
        if ({y_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_row_end: got v=%b busy=%b, expected 0 0", y_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int exp_k = 0, cyc = 0;
        y_in = pack(32'hA0, 32'hA1, 32'hA2, 32'hA3); en_y = 1; y_ready = 0;
        @(negedge clk);
        en_y = 0;
        while (exp_k < 4 && cyc < 40) begin
            checks++;
            if ({y_valid, y_idx, y_out} !== {1'b1, 2'(exp_k), 16'(32'hA0 + exp_k)}) begin
                errors++;
                $display("FAIL backpressure cyc%0d: got v=%b idx=%0d out=%h, expected v=1 idx=%0d out=%h",
                         cyc, y_valid, y_idx, y_out, exp_k, 32'hA0 + exp_k);
            end
            y_ready = pat[cyc % 4];
            if (y_valid && y_ready) exp_k++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (exp_k != 4 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_end: got delivered=%0d v=%b, expected 4 and v=0", exp_k, y_valid);
        end
        y_ready = 1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_v [8] = '{16'h11, 16'h12, 16'h13, 16'h14, 16'h21, 16'h22, 16'h23, 16'h24};
        y_in = pack(32'h11, 32'h12, 32'h13, 32'h14); en_y = 1; y_ready = 1;
        @(negedge clk);
        en_y = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                y_in = pack(32'h21, 32'h22, 32'h23, 32'h24); en_y = 1;
            end else begin
                en_y = 0;
            end
            checks++;
            if ({y_valid, y_out} !== {1'b1, exp_v[i]}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got v=%b out=%h, expected v=1 out=%h", i, y_valid, y_out, exp_v[i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({y_valid, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL back_to_back_end: got v=%b overrun=%b, expected 0 0", y_valid, overrun);
        end
    endtask

    task automatic test_last_capture();
        logic [15:0] exp_v [8] = '{16'h51, 16'h52, 16'h53, 16'h54, 16'h61, 16'h62, 16'h63, 16'h64};
        y_in = pack(32'h51, 32'h52, 32'h53, 32'h54); en_y = 1; y_ready = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                y_in = pack(32'h61, 32'h62, 32'h63, 32'h64); en_y = 1;
            end else begin
                en_y = 0;
            end
            checks++;
            if ({y_valid, y_out} !== {1'b1, exp_v[i]}) begin
                errors++;
                $display("FAIL last_capture[%0d]: got v=%b out=%h, expected v=1 out=%h", i, y_valid, y_out, exp_v[i]);
            end
            @(negedge clk);
        end
        checks++;
        if ({y_valid, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL last_capture_end: got v=%b overrun=%b, expected 0 0", y_valid, overrun);
        end
    endtask

    task automatic test_overrun();
        y_ready = 0;
        y_in = pack(32'h100, 32'h101, 32'h102, 32'h103); en_y = 1;
        @(negedge clk);
        y_in = pack(32'h200, 32'h201, 32'h202, 32'h203);
        @(negedge clk);
        y_in = pack(32'h300, 32'h301, 32'h302, 32'h303);
        @(negedge clk);
        en_y = 0;
        checks++;
        if ({overrun, busy, y_valid, y_out} !== {3'b111, 16'h100}) begin
            errors++;
            $display("FAIL overrun_set: got o=%b b=%b v=%b out=%h, expected 1 1 1 0100", overrun, busy, y_valid, y_out);
        end
        overrun_clr = 1;
        @(negedge clk);
        overrun_clr = 0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b, expected 0", overrun);
        end
        en_y = 1; overrun_clr = 1;
        @(negedge clk);
        en_y = 0; overrun_clr = 0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set_beats_clr: got %b, expected 1", overrun);
        end
        overrun_clr = 1;
        @(negedge clk);
        overrun_clr = 0; y_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({y_valid, y_out} !== {1'b1, 16'((i < 4) ? (32'h100 + i) : (32'h200 + i - 4))}) begin
                errors++;
                $display("FAIL overrun_drain[%0d]: got v=%b out=%h, expected v=1 out=%h", i, y_valid, y_out,
                         (i < 4) ? (32'h100 + i) : (32'h200 + i - 4));
            end
            @(negedge clk);
        end
        checks++;
        if ({y_valid, busy, overrun} !== 3'b000) begin
            errors++;
            $display("FAIL overrun_end: got v=%b b=%b o=%b, expected 0 0 0", y_valid, busy, overrun);
        end
    endtask

    task automatic test_saturate();
`ifdef Y_SATURATE_EN
        logic [15:0] exp_v [4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
`else
        logic [15:0] exp_v [4] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h8000};
`endif
        y_in = pack(32'h0001_0000, 32'hFFFF_0000, 32'h0000_7FFF, 32'h0000_8000); en_y = 1; y_ready = 1;
        @(negedge clk);
        en_y = 0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({y_valid, y_out} !== {1'b1, exp_v[k]}) begin
                errors++;
                $display("FAIL convert[%0d]: got v=%b out=%h, expected v=1 out=%h", k, y_valid, y_out, exp_v[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_drain();
        y_in = pack(32'h71, 32'h72, 32'h73, 32'h74); en_y = 1; y_ready = 1;
        @(negedge clk);
        y_in = pack(32'h81, 32'h82, 32'h83, 32'h84);
        @(negedge clk);
        en_y = 0;
        reset = 1'b0;
        #1;
        checks++;
        if ({y_valid, y_last, busy, overrun, y_idx, y_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid_drain: got v=%b l=%b b=%b o=%b idx=%0d out=%h, expected all 0",
                     y_valid, y_last, busy, overrun, y_idx, y_out);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({y_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL post_reset_idle[%0d]: got v=%b b=%b, expected 0 0", i, y_valid, busy);
            end
        end
        y_in = pack(32'h91, 32'h92, 32'h93, 32'h94); en_y = 1;
        @(negedge clk);
        en_y = 0;
        checks++;
        if ({y_valid, y_idx, y_out} !== {1'b1, 2'd0, 16'h91}) begin
            errors++;
            $display("FAIL post_reset_row: got v=%b idx=%0d out=%h, expected v=1 idx=0 out=0091", y_valid, y_idx, y_out);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_back_to_back();
        test_last_capture();
        test_overrun();
        test_saturate();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion before 100000");
        $fatal(1);
    end
endmodule
